// File: rtl/wb_trace_packer_pkg.sv
// wb_trace_packer_pkg: shared FSM state type and frame constants for the writeback trace packer
package wb_trace_packer_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int FRAME_LEN = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO, no bypass (a push is visible at dout one cycle later)
// ports: clk, rst (async, active-high), push/din write side, pop/dout read side, full, empty
module trace_fifo #(
    parameter int W = 37,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr, rd;
    // the extra top pointer bit tells a full FIFO from an empty one when the addresses match
    assign empty = wr == rd;
    assign full = wr[AW] != rd[AW] && wr[AW-1:0] == rd[AW-1:0];
    assign dout = mem[rd[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push && !full) wr <= wr + 1'b1;
            if (pop && !empty) rd <= rd + 1'b1;
        end
    always_ff @(posedge clk)
        if (push && !full) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/wb_trace_packer.sv
// wb_trace_packer: buffers register-file writes and streams them as 7-byte frames to a UART byte transmitter
// ports: clk, resetn (async, active-high), wb_wreg/wb_wd/wb_wdata writeback capture,
//        tx_data/tx_valid/tx_ready byte stream, ovf_cnt saturating drop count, busy
module wb_trace_packer
    import wb_trace_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_wreg,
    input  logic [4:0]  wb_wd,
    input  logic [31:0] wb_wdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  ovf_cnt,
    output logic        busy
);
    state_t state, state_n;
    logic ev, push, pop, full, empty, last;
    logic [36:0] head, frame;
    logic [2:0] idx;
    logic [7:0] chk;
    logic [8*FRAME_LEN-1:0] frame_bytes;
    assign ev = wb_wreg && wb_wd != 5'd0;
    assign push = ev && !full;
    assign pop = state == IDLE && !empty;
    assign last = idx == 3'(FRAME_LEN - 1);
    assign chk = {3'b000, frame[36:32]} ^ frame[31:24] ^ frame[23:16] ^ frame[15:8] ^ frame[7:0];
    assign frame_bytes = {SYNC_BYTE, 3'b000, frame[36:32], frame[31:0], chk};
    assign tx_valid = state == SEND;
    assign tx_data = tx_valid ? frame_bytes[8*(FRAME_LEN-1-int'(idx)) +: 8] : 8'h00;
    assign busy = !empty || state == SEND;
    trace_fifo #(.W(37), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(resetn),
        .push(push),
        .din({wb_wd, wb_wdata}),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (empty ? IDLE : SEND) : (tx_ready && last ? IDLE : SEND);
    end
    always_ff @(posedge clk or posedge resetn)
        if (resetn) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            frame <= '0;
            idx <= '0;
            ovf_cnt <= '0;
        end else begin
            if (pop) begin
                frame <= head;
                idx <= '0;
            end else if (state == SEND && tx_ready) begin
                idx <= last ? 3'd0 : idx + 3'd1;
            end
            // fullness is judged at the start of the cycle, so a same-cycle pop never saves the event
            if (ev && full && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
endmodule
